// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, reset defaults, BTB lookup bundle.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [1:0]  CNT_RESET    = 2'b01;

  typedef struct packed {
    logic        taken;
    logic [31:0] next_pc;
  } pred_t;

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Combinational lookup, update at the clock edge.
module branch_predictor_btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output pred_t       pred,
  input  logic        upd,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] u_tag;
  logic             l_hit;
  logic             u_hit;
  logic             unused_bits;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  always_comb begin
    pred.taken   = l_hit && cnt_q[l_idx][1];
    pred.next_pc = pred.taken ? tgt_q[l_idx] : lookup_pc + 32'd4;
  end

  // tag/target need no reset: they are only read behind valid_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
    end else if (upd) begin
      if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= {upd_target[31:2], 2'b00};
        if (cnt_q[u_idx] != 2'b11)
          cnt_q[u_idx] <= cnt_q[u_idx] + 2'b01;
      end else if (u_hit && cnt_q[u_idx] != 2'b00) begin
        cnt_q[u_idx] <= cnt_q[u_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests,
// BTB next-PC prediction, IF/ID handshake and EX redirect.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          BTB_ENTRIES = 16,
  parameter int          IDX_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        predicted_out,
  input  logic        enable,
  input  logic        IFIDWrite,
  input  logic        Flush,
  input  logic [31:0] redirect_pc,
  input  logic        bp_update,
  input  logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc_q, npc_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  instr_q, instr_d;
  logic         pred_q, pred_d;
  logic         accept;
  logic         unused_bits;
  pred_t        lk;

  branch_predictor_btb #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc_q),
    .pred       (lk),
    .upd        (bp_update),
    .upd_pc     (bp_pc),
    .upd_taken  (bp_taken),
    .upd_target (bp_target)
  );

  assign unused_bits    = ^redirect_pc[1:0];
  assign imem_req_valid = rst && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign fetch_valid    = (state_q == S_HOLD);
  assign instruction    = fetch_valid ? instr_q : 32'h0;
  assign pc_out         = fetch_valid ? fpc_q : 32'h0;
  assign predicted_out  = fetch_valid && pred_q;
  assign accept         = fetch_valid && enable && IFIDWrite;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    fpc_d   = fpc_q;
    instr_d = instr_q;
    pred_d  = pred_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          fpc_d   = pc_q;
          pred_d  = lk.taken;
          npc_d   = lk.next_pc;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_HOLD;
          instr_d = imem_rsp_data;
        end
      end
      S_HOLD: begin
        if (accept) begin
          state_d = S_REQ;
          pc_d    = npc_q;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    // an accepted-but-unanswered request must be drained after redirect
    if (Flush) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      npc_q   <= '0;
      fpc_q   <= '0;
      instr_q <= '0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pred_q  <= pred_d;
    end
  end

endmodule
